// File: rtl/wb_queue_pkg.sv
// wb_queue_pkg: shared widths and constants for the write-back merge buffer.
// Rev 1.0
`default_nettype none

package wb_queue_pkg;

    localparam int WB_DW    = 32;
    localparam int WB_AW    = 5;
    localparam int WB_DEPTH = 4;

    localparam logic [WB_AW-1:0] REG_ZERO = 5'd0;

    // Pointer width that stays legal for the smallest (DEPTH=2) configuration.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_fwd_lookup.sv
// wb_fwd_lookup: youngest-match search across the pending write-back entries.
// Rev 1.0
`default_nettype none

module wb_fwd_lookup #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int PW    = 2
) (
    input  logic [DEPTH-1:0]         ent_valid,
    input  logic [DEPTH-1:0][AW-1:0] ent_addr,
    input  logic [DEPTH-1:0][DW-1:0] ent_data,
    input  logic [PW-1:0]            head,
    input  logic [AW-1:0]            addr,
    output logic                     hit,
    output logic [DW-1:0]            data
);

    logic [PW-1:0] idx;

    // Walk oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = head;
        if (addr != '0) begin
            for (int i = 0; i < DEPTH; i++) begin
                idx = head + PW'(i);
                if (ent_valid[idx] && (ent_addr[idx] == addr)) begin
                    hit  = 1'b1;
                    data = ent_data[idx];
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_queue.sv
// wb_queue: two-producer write-back merge buffer feeding one register-file write port,
// with operand forwarding from pending entries. Rev 1.0
`default_nettype none

module wb_queue
    import wb_queue_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int DW    = WB_DW,
    parameter int AW    = WB_AW
) (
    input  logic          clk_port,
    input  logic          rst_port,
    input  logic          mem_valid,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_data,
    input  logic          alu_valid,
    input  logic [AW-1:0] alu_addr,
    input  logic [DW-1:0] alu_data,
    output logic          in_ready,
    output logic          wr,
    output logic [AW-1:0] address_d,
    output logic [DW-1:0] data_d,
    input  logic [AW-1:0] fwd_addr_a,
    output logic          fwd_hit_a,
    output logic [DW-1:0] fwd_data_a,
    input  logic [AW-1:0] fwd_addr_b,
    output logic          fwd_hit_b,
    output logic [DW-1:0] fwd_data_b,
    output logic [AW-1:0] count,
    output logic          drop_err
);

    localparam int PW = ptr_width(DEPTH);
    localparam logic [AW-1:0] READY_MAX = AW'(DEPTH - 2);

    logic [DEPTH-1:0]         ent_valid;
    logic [DEPTH-1:0][AW-1:0] ent_addr;
    logic [DEPTH-1:0][DW-1:0] ent_data;
    logic [PW-1:0]            head;
    logic [PW-1:0]            tail;

    logic          push_mem;
    logic          push_alu;
    logic          pop;
    logic          any_valid;
    logic [PW-1:0] alu_slot;
    logic [PW-1:0] tail_next;
    logic [AW-1:0] count_next;

    assign in_ready  = (count <= READY_MAX);
    assign any_valid = mem_valid | alu_valid;
    assign push_mem  = mem_valid & in_ready & (mem_addr != AW'(REG_ZERO));
    assign push_alu  = alu_valid & in_ready & (alu_addr != AW'(REG_ZERO));
    assign pop       = (count != '0);

    // The alu entry is younger, so it lands one slot behind the mem entry.
    assign alu_slot   = tail + PW'(push_mem);
    assign tail_next  = tail + PW'(push_mem) + PW'(push_alu);
    assign count_next = count + AW'(push_mem) + AW'(push_alu) - AW'(pop);

    always_ff @(posedge clk_port or negedge rst_port) begin
        if (!rst_port) begin
            ent_valid <= '0;
            ent_addr  <= '0;
            ent_data  <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            drop_err  <= 1'b0;
        end else begin
            // Pushes only target free slots, so they never collide with the popped head.
            if (pop) begin
                ent_valid[head] <= 1'b0;
                head            <= head + PW'(1);
            end
            if (push_mem) begin
                ent_valid[tail] <= 1'b1;
                ent_addr[tail]  <= mem_addr;
                ent_data[tail]  <= mem_data;
            end
            if (push_alu) begin
                ent_valid[alu_slot] <= 1'b1;
                ent_addr[alu_slot]  <= alu_addr;
                ent_data[alu_slot]  <= alu_data;
            end
            tail  <= tail_next;
            count <= count_next;
            if (any_valid && !in_ready) begin
                drop_err <= 1'b1;
            end
        end
    end

    assign wr        = pop;
    assign address_d = pop ? ent_addr[head] : '0;
    assign data_d    = pop ? ent_data[head] : '0;

    wb_fwd_lookup #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .AW    (AW),
        .PW    (PW)
    ) u_fwd_a (
        .ent_valid (ent_valid),
        .ent_addr  (ent_addr),
        .ent_data  (ent_data),
        .head      (head),
        .addr      (fwd_addr_a),
        .hit       (fwd_hit_a),
        .data      (fwd_data_a)
    );

    wb_fwd_lookup #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .AW    (AW),
        .PW    (PW)
    ) u_fwd_b (
        .ent_valid (ent_valid),
        .ent_addr  (ent_addr),
        .ent_data  (ent_data),
        .head      (head),
        .addr      (fwd_addr_b),
        .hit       (fwd_hit_b),
        .data      (fwd_data_b)
    );

endmodule

`default_nettype wire

// File: tb/tb_wb_queue.sv
// tb_wb_queue: randomized and directed checks of wb_queue against a queue-based model.
// Rev 1.0
`default_nettype none

module tb_wb_queue;

    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int AW    = 5;

    logic          clk_port;
    logic          rst_port;
    logic          mem_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          alu_valid;
    logic [AW-1:0] alu_addr;
    logic [DW-1:0] alu_data;
    logic          in_ready;
    logic          wr;
    logic [AW-1:0] address_d;
    logic [DW-1:0] data_d;
    logic [AW-1:0] fwd_addr_a;
    logic          fwd_hit_a;
    logic [DW-1:0] fwd_data_a;
    logic [AW-1:0] fwd_addr_b;
    logic          fwd_hit_b;
    logic [DW-1:0] fwd_data_b;
    logic [AW-1:0] count;
    logic          drop_err;

    wb_queue #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .clk_port   (clk_port),
        .rst_port   (rst_port),
        .mem_valid  (mem_valid),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .alu_valid  (alu_valid),
        .alu_addr   (alu_addr),
        .alu_data   (alu_data),
        .in_ready   (in_ready),
        .wr         (wr),
        .address_d  (address_d),
        .data_d     (data_d),
        .fwd_addr_a (fwd_addr_a),
        .fwd_hit_a  (fwd_hit_a),
        .fwd_data_a (fwd_data_a),
        .fwd_addr_b (fwd_addr_b),
        .fwd_hit_b  (fwd_hit_b),
        .fwd_data_b (fwd_data_b),
        .count      (count),
        .drop_err   (drop_err)
    );

    initial clk_port = 1'b0;
    always #5 clk_port = ~clk_port;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t m_q[$];
    logic m_drop;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW:0] m_fwd(input logic [AW-1:0] addr);
        if (addr == '0) return '0;
        for (int i = m_q.size() - 1; i >= 0; i--) begin
            if (m_q[i].a == addr) return {1'b1, m_q[i].d};
        end
        return '0;
    endfunction

    task automatic compare();
        logic [DW:0] fa;
        logic [DW:0] fb;
        int n;
        n  = m_q.size();
        fa = m_fwd(fwd_addr_a);
        fb = m_fwd(fwd_addr_b);
        chk("count", 64'(count), 64'(n));
        chk("in_ready", 64'(in_ready), 64'(DEPTH - n >= 2));
        chk("wr", 64'(wr), 64'(n > 0));
        chk("address_d", 64'(address_d), (n > 0) ? 64'(m_q[0].a) : 64'd0);
        chk("data_d", 64'(data_d), (n > 0) ? 64'(m_q[0].d) : 64'd0);
        chk("fwd_a", 64'({fwd_hit_a, fwd_data_a}), 64'(fa));
        chk("fwd_b", 64'({fwd_hit_b, fwd_data_b}), 64'(fb));
        chk("drop_err", 64'(drop_err), 64'(m_drop));
    endtask

    task automatic model_update();
        bit ready;
        ready = (DEPTH - m_q.size() >= 2);
        if (m_q.size() > 0) void'(m_q.pop_front());
        if (ready) begin
            if (mem_valid && mem_addr != '0) m_q.push_back('{a: mem_addr, d: mem_data});
            if (alu_valid && alu_addr != '0) m_q.push_back('{a: alu_addr, d: alu_data});
        end else if (mem_valid || alu_valid) begin
            m_drop = 1'b1;
        end
    endtask

    task automatic step();
        @(negedge clk_port);
        compare();
        model_update();
        @(posedge clk_port);
        #1;
    endtask

    task automatic set_in(input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md,
                          input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                          input logic [AW-1:0] fa, input logic [AW-1:0] fb);
        mem_valid  = mv;
        mem_addr   = ma;
        mem_data   = md;
        alu_valid  = av;
        alu_addr   = aa;
        alu_data   = ad;
        fwd_addr_a = fa;
        fwd_addr_b = fb;
    endtask

    task automatic idle(input logic [AW-1:0] fa);
        set_in(0, 0, 0, 0, 0, 0, fa, fa);
    endtask

    initial begin
        m_drop   = 1'b0;
        rst_port = 1'b0;
        idle(0);
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_wr", 64'(wr), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_drop_err", 64'(drop_err), 64'd0);
        #11 rst_port = 1'b1;
        @(posedge clk_port);
        #1;

        // Single write and forwarding of the head entry.
        set_in(0, 0, 0, 1, 5, 32'hDEADBEEF, 5, 0);
        #1 chk("same_cycle_no_fwd", 64'(fwd_hit_a), 64'd0);
        step();
        idle(5);
        #1;
        chk("single_wr", 64'(wr), 64'd1);
        chk("single_addr", 64'(address_d), 64'd5);
        chk("single_data", 64'(data_d), 64'hDEADBEEF);
        chk("single_fwd", 64'({fwd_hit_a, fwd_data_a}), {31'd0, 1'b1, 32'hDEADBEEF});
        step();
        #1 chk("single_drained", 64'(count), 64'd0);

        // Dual same-address write: older mem first, alu wins in forwarding.
        set_in(1, 7, 32'h1, 1, 7, 32'h2, 7, 7);
        step();
        idle(7);
        #1;
        chk("dual_count", 64'(count), 64'd2);
        chk("dual_first", 64'(data_d), 64'h1);
        chk("dual_fwd", 64'(fwd_data_a), 64'h2);
        step();
        #1 chk("dual_second", 64'(data_d), 64'h2);
        step();
        #1 chk("dual_done_hit", 64'(fwd_hit_b), 64'd0);

        // Register zero is never enqueued or forwarded.
        set_in(0, 0, 0, 1, 0, 32'h55, 0, 0);
        step();
        idle(0);
        #1;
        chk("r0_count", 64'(count), 64'd0);
        chk("r0_wr", 64'(wr), 64'd0);
        chk("r0_hit", 64'(fwd_hit_a), 64'd0);

        // Fill: two pushes per cycle until the buffer refuses, then one drop.
        set_in(1, 1, 32'h11, 1, 2, 32'h22, 1, 2);
        step();
        set_in(1, 3, 32'h33, 1, 4, 32'h44, 3, 4);
        step();
        #1;
        chk("full_count", 64'(count), 64'd3);
        chk("full_ready", 64'(in_ready), 64'd0);
        set_in(1, 5, 32'h55, 1, 6, 32'h66, 5, 6);
        step();
        idle(0);
        #1;
        chk("drop_set", 64'(drop_err), 64'd1);
        chk("drop_count", 64'(count), 64'd2);
        step();
        step();

        // Back-to-back single alu pushes keep exactly one entry in flight.
        for (int i = 0; i < 10; i++) begin
            set_in(0, 0, 0, 1, AW'(8 + i), 32'hA000 + 32'(i), AW'(8 + i), 0);
            step();
            #0 chk("b2b_count", 64'(count), 64'd1);
        end
        idle(0);
        step();

        // Asynchronous reset mid-traffic with three entries pending.
        set_in(1, 9, 32'h9, 1, 10, 32'hA, 9, 10);
        step();
        set_in(1, 11, 32'hB, 1, 12, 32'hC, 11, 12);
        step();
        idle(11);
        #1 chk("pre_rst_count", 64'(count), 64'd3);
        rst_port = 1'b0;
        #1;
        chk("async_rst_count", 64'(count), 64'd0);
        chk("async_rst_wr", 64'(wr), 64'd0);
        chk("async_rst_ready", 64'(in_ready), 64'd1);
        chk("async_rst_drop", 64'(drop_err), 64'd0);
        m_q.delete();
        m_drop = 1'b0;
        #1 rst_port = 1'b1;

        // Randomized traffic; occasional overrun to exercise the drop path.
        for (int i = 0; i < 400; i++) begin
            logic ok;
            ok = (DEPTH - m_q.size() >= 2) || ($urandom_range(0, 24) == 0);
            set_in(ok && ($urandom_range(0, 2) != 0), AW'($urandom_range(0, 7)), $urandom,
                   ok && ($urandom_range(0, 2) != 0), AW'($urandom_range(0, 7)), $urandom,
                   AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
            step();
        end
        idle(0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
